rob_cmpl_arbiter: RTL and testbench

Completion-port arbiter between the execution units and the reorder buffer's single probe/finish write port. Three requesters (0 = ALU, 1 = MEM, 2 = branch unit) each hand over completion records through a valid/ready handshake into a one-entry holding register. A round-robin scheduler issues at most one record per cycle to the ROB as a registered one-cycle probe pulse. Records whose ROB index is no longer occupied are discarded, and all pending work is dropped on a pipeline flush.

---
 rtl/rob_cmpl_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_rob_cmpl_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_cmpl_arbiter.sv
// rob_cmpl_arbiter: collects completion records from the ALU, MEM and branch
// units into one-entry holding registers. It round-robin arbitrates them onto
// the single ROB probe/finish port as a registered one-cycle strobe. Records
// whose ROB index is no longer occupied are discarded and counted.
module rob_cmpl_arbiter #(
    parameter int unsigned ROB_ADDRWIDTH = 6,
    parameter int unsigned CNT_WIDTH     = 8
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       FREEZE,
    input  logic                       flush_IN,
    input  logic [2:0]                 cmplValid_IN,
    output logic [2:0]                 cmplReady_OUT,
    input  logic [3*ROB_ADDRWIDTH-1:0] cmplIdx_IN,
    input  logic [2:0]                 cmplExp_IN,
    input  logic [2:0]                 cmplTaken_IN,
    input  logic [95:0]                cmplTarget_IN,
    input  logic [ROB_ADDRWIDTH-1:0]   fROB_curHead_IN,
    input  logic [ROB_ADDRWIDTH-1:0]   fROB_curTail_IN,
    input  logic                       fROB_empty_IN,
    output logic [ROB_ADDRWIDTH-1:0]   tROB_probeIdx_OUT,
    output logic                       tROB_probeSetFinBit_OUT,
    output logic                       tROB_probeSetExpBit_OUT,
    output logic                       tROB_probe_taken_branch,
    output logic [31:0]                tROB_probe_target_PC,
    output logic [CNT_WIDTH-1:0]       dropCount_OUT
);

    localparam int unsigned NREQ = 3;

    // Round-robin pointer: the requester searched first in the next cycle.
    typedef enum logic [1:0] {
        RR_ALU = 2'd0,
        RR_MEM = 2'd1,
        RR_BR  = 2'd2
    } rr_t;

    rr_t rr_ptr;

    // Holding registers, one per requester.
    logic [NREQ-1:0]          held;
    logic [ROB_ADDRWIDTH-1:0] rec_idx    [NREQ];
    logic                     rec_exp    [NREQ];
    logic                     rec_taken  [NREQ];
    logic [31:0]              rec_target [NREQ];

    // Unpacked views of the flattened input buses.
    logic [ROB_ADDRWIDTH-1:0] in_idx    [NREQ];
    logic [31:0]              in_target [NREQ];

    // Arbitration results.
    logic                     active;
    logic                     grant_found;
    rr_t                      grant_sel;
    rr_t                      cand;
    logic [NREQ-1:0]          grant;
    logic [NREQ-1:0]          accept;
    logic [ROB_ADDRWIDTH-1:0] sel_idx;
    logic                     sel_occupied;

    function automatic rr_t rr_step(input rr_t p);
        case (p)
            RR_ALU:  return RR_MEM;
            RR_MEM:  return RR_BR;
            default: return RR_ALU;
        endcase
    endfunction

    // H == T is ambiguous between full and empty, so the empty flag decides.
    function automatic logic is_occupied(
        input logic [ROB_ADDRWIDTH-1:0] idx,
        input logic [ROB_ADDRWIDTH-1:0] head,
        input logic [ROB_ADDRWIDTH-1:0] tail,
        input logic                     empty
    );
        if (head < tail) begin
            return (idx >= head) && (idx < tail);
        end else if (head > tail) begin
            return (idx >= head) || (idx < tail);
        end else begin
            return !empty;
        end
    endfunction

    // Slice the flattened per-requester buses into arrays.
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            in_idx[i]    = cmplIdx_IN[i*ROB_ADDRWIDTH +: ROB_ADDRWIDTH];
            in_target[i] = cmplTarget_IN[i*32 +: 32];
        end
    end

    assign active = !RESET && !FREEZE && !flush_IN;

    // Find the first held entry, starting at rr_ptr and wrapping 2 -> 0.
    always_comb begin
        grant_found = 1'b0;
        grant_sel   = RR_ALU;
        cand        = rr_ptr;
        if (active) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                if (!grant_found && held[cand]) begin
                    grant_found = 1'b1;
                    grant_sel   = cand;
                end
                cand = rr_step(cand);
            end
        end
    end

    assign grant = grant_found ? (3'b001 << grant_sel) : '0;

    // A granted slot frees up in the same cycle, so it can take a new record.
    assign cmplReady_OUT = {NREQ{active}} & (~held | grant);
    assign accept        = cmplValid_IN & cmplReady_OUT;

    assign sel_idx      = rec_idx[grant_sel];
    assign sel_occupied = is_occupied(sel_idx, fROB_curHead_IN,
                                      fROB_curTail_IN, fROB_empty_IN);

    // Holding registers: capture on handshake, release on grant, clear on flush.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            held <= '0;
            for (int unsigned i = 0; i < NREQ; i++) begin
                rec_idx[i]    <= '0;
                rec_exp[i]    <= 1'b0;
                rec_taken[i]  <= 1'b0;
                rec_target[i] <= '0;
            end
        end else if (flush_IN) begin
            held <= '0;
        end else if (!FREEZE) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                // A refill in the grant cycle takes precedence over the release.
                if (accept[i]) begin
                    held[i]       <= 1'b1;
                    rec_idx[i]    <= in_idx[i];
                    rec_exp[i]    <= cmplExp_IN[i];
                    rec_taken[i]  <= cmplTaken_IN[i];
                    rec_target[i] <= in_target[i];
                end else if (grant[i]) begin
                    held[i] <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointer: advance past the winner, return to 0 on flush.
    always_ff @(posedge CLK) begin
        if (RESET || flush_IN) begin
            rr_ptr <= RR_ALU;
        end else if (grant_found) begin
            rr_ptr <= rr_step(grant_sel);
        end
    end

    // Probe outputs and drop counter: the strobe defaults low every cycle.
    // The grant is already suppressed under FREEZE/flush, so those cases
    // leave only that default.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            tROB_probeIdx_OUT       <= '0;
            tROB_probeSetFinBit_OUT <= 1'b0;
            tROB_probeSetExpBit_OUT <= 1'b0;
            tROB_probe_taken_branch <= 1'b0;
            tROB_probe_target_PC    <= '0;
            dropCount_OUT           <= '0;
        end else begin
            tROB_probeSetFinBit_OUT <= 1'b0;
            if (grant_found) begin
                if (sel_occupied) begin
                    tROB_probeIdx_OUT       <= sel_idx;
                    tROB_probeSetFinBit_OUT <= 1'b1;
                    tROB_probeSetExpBit_OUT <= rec_exp[grant_sel];
                    tROB_probe_taken_branch <= rec_taken[grant_sel];
                    tROB_probe_target_PC    <= rec_target[grant_sel];
                end else if (dropCount_OUT != '1) begin
                    dropCount_OUT <= dropCount_OUT + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_cmpl_arbiter.sv
// Testbench for rob_cmpl_arbiter: directed scenarios followed by a random
// phase, all compared every cycle against a queue/array-level reference model.
module tb_rob_cmpl_arbiter;

    localparam int AW    = 6;
    localparam int CW    = 8;
    localparam int DEPTH = 1 << AW;

    logic            CLK = 1'b0;
    logic            RESET;
    logic            FREEZE;
    logic            flush_IN;
    logic [2:0]      cmplValid_IN;
    logic [2:0]      cmplReady_OUT;
    logic [3*AW-1:0] cmplIdx_IN;
    logic [2:0]      cmplExp_IN;
    logic [2:0]      cmplTaken_IN;
    logic [95:0]     cmplTarget_IN;
    logic [AW-1:0]   fROB_curHead_IN;
    logic [AW-1:0]   fROB_curTail_IN;
    logic            fROB_empty_IN;
    logic [AW-1:0]   tROB_probeIdx_OUT;
    logic            tROB_probeSetFinBit_OUT;
    logic            tROB_probeSetExpBit_OUT;
    logic            tROB_probe_taken_branch;
    logic [31:0]     tROB_probe_target_PC;
    logic [CW-1:0]   dropCount_OUT;

    rob_cmpl_arbiter #(.ROB_ADDRWIDTH(AW), .CNT_WIDTH(CW)) dut (
        .CLK                     (CLK),
        .RESET                   (RESET),
        .FREEZE                  (FREEZE),
        .flush_IN                (flush_IN),
        .cmplValid_IN            (cmplValid_IN),
        .cmplReady_OUT           (cmplReady_OUT),
        .cmplIdx_IN              (cmplIdx_IN),
        .cmplExp_IN              (cmplExp_IN),
        .cmplTaken_IN            (cmplTaken_IN),
        .cmplTarget_IN           (cmplTarget_IN),
        .fROB_curHead_IN         (fROB_curHead_IN),
        .fROB_curTail_IN         (fROB_curTail_IN),
        .fROB_empty_IN           (fROB_empty_IN),
        .tROB_probeIdx_OUT       (tROB_probeIdx_OUT),
        .tROB_probeSetFinBit_OUT (tROB_probeSetFinBit_OUT),
        .tROB_probeSetExpBit_OUT (tROB_probeSetExpBit_OUT),
        .tROB_probe_taken_branch (tROB_probe_taken_branch),
        .tROB_probe_target_PC    (tROB_probe_target_PC),
        .dropCount_OUT           (dropCount_OUT)
    );

    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state.
    bit          m_held [3];
    int          m_idx  [3];
    bit          m_exp  [3];
    bit          m_tk   [3];
    logic [31:0] m_tgt  [3];
    int          m_rr;
    int          m_drop;
    int          m_grant;
    bit          m_ready [3];
    bit          e_fin, e_exp, e_tk;
    int          e_idx;
    logic [31:0] e_tgt;

    int strobes[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // An index is live if its distance from head is within the head->tail span.
    function automatic bit m_occ(input int idx, input int h, input int t, input bit empty);
        if (h == t) return !empty;
        return ((idx - h + DEPTH) % DEPTH) < ((t - h + DEPTH) % DEPTH);
    endfunction

    task automatic model_arbitrate();
        bit active;
        active  = !RESET && !FREEZE && !flush_IN;
        m_grant = -1;
        if (active) begin
            for (int k = 0; k < 3; k++) begin
                int j;
                j = (m_rr + k) % 3;
                if (m_grant < 0 && m_held[j]) m_grant = j;
            end
        end
        for (int i = 0; i < 3; i++) m_ready[i] = active && (!m_held[i] || m_grant == i);
    endtask

    task automatic model_edge();
        if (RESET) begin
            for (int i = 0; i < 3; i++) m_held[i] = 0;
            m_rr = 0; m_drop = 0;
            e_fin = 0; e_exp = 0; e_tk = 0; e_idx = 0; e_tgt = '0;
        end else if (flush_IN) begin
            for (int i = 0; i < 3; i++) m_held[i] = 0;
            m_rr = 0; e_fin = 0;
        end else if (FREEZE) begin
            e_fin = 0;
        end else begin
            e_fin = 0;
            if (m_grant >= 0) begin
                m_rr = (m_grant + 1) % 3;
                if (m_occ(m_idx[m_grant], int'(fROB_curHead_IN), int'(fROB_curTail_IN), fROB_empty_IN)) begin
                    e_fin = 1;
                    e_idx = m_idx[m_grant];
                    e_exp = m_exp[m_grant];
                    e_tk  = m_tk[m_grant];
                    e_tgt = m_tgt[m_grant];
                end else if (m_drop < (1 << CW) - 1) begin
                    m_drop++;
                end
                m_held[m_grant] = 0;
            end
            for (int i = 0; i < 3; i++) begin
                if (cmplValid_IN[i] && m_ready[i]) begin
                    m_held[i] = 1;
                    m_idx[i]  = int'(cmplIdx_IN[i*AW +: AW]);
                    m_exp[i]  = cmplExp_IN[i];
                    m_tk[i]   = cmplTaken_IN[i];
                    m_tgt[i]  = cmplTarget_IN[i*32 +: 32];
                end
            end
        end
    endtask

    // One clock: ready checked at the falling edge, outputs 1 time unit after the rise.
    task automatic tick();
        #4;
        model_arbitrate();
        for (int i = 0; i < 3; i++)
            check($sformatf("ready%0d", i), 32'(cmplReady_OUT[i]), 32'(m_ready[i]));
        @(posedge CLK);
        model_edge();
        #1;
        check("fin",    32'(tROB_probeSetFinBit_OUT), 32'(e_fin));
        check("idx",    32'(tROB_probeIdx_OUT),       32'(e_idx));
        check("exp",    32'(tROB_probeSetExpBit_OUT), 32'(e_exp));
        check("taken",  32'(tROB_probe_taken_branch), 32'(e_tk));
        check("target", tROB_probe_target_PC,         e_tgt);
        check("drop",   32'(dropCount_OUT),           32'(m_drop));
        if (tROB_probeSetFinBit_OUT === 1'b1) strobes.push_back(int'(tROB_probeIdx_OUT));
    endtask

    task automatic set_req(input int i, input bit v, input int idx, input bit ex,
                           input bit tk, input logic [31:0] tg);
        cmplValid_IN[i]         = v;
        cmplIdx_IN[i*AW +: AW]  = AW'(idx);
        cmplExp_IN[i]           = ex;
        cmplTaken_IN[i]         = tk;
        cmplTarget_IN[i*32 +: 32] = tg;
    endtask

    task automatic set_rob(input int h, input int t, input bit e);
        fROB_curHead_IN = AW'(h);
        fROB_curTail_IN = AW'(t);
        fROB_empty_IN   = e;
    endtask

    task automatic do_flush();
        cmplValid_IN = '0;
        flush_IN = 1'b1;
        tick();
        flush_IN = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; FREEZE = 1'b0; flush_IN = 1'b0;
        cmplValid_IN = '0; cmplIdx_IN = '0; cmplExp_IN = '0; cmplTaken_IN = '0;
        cmplTarget_IN = '0;
        set_rob(0, 0, 1'b1);
        @(posedge CLK); #1;

        // Reset for two cycles.
        tick(); tick();
        RESET = 1'b0;

        // Single accept on requester 1 with one-cycle probe latency.
        set_rob(3, 9, 1'b0);
        set_req(1, 1, 5, 0, 1, 32'h0040_0100);
        tick();
        cmplValid_IN = '0;
        tick();
        check("tp_accept_fin",    32'(tROB_probeSetFinBit_OUT), 32'd1);
        check("tp_accept_idx",    32'(tROB_probeIdx_OUT),       32'd5);
        check("tp_accept_target", tROB_probe_target_PC,         32'h0040_0100);
        tick();
        check("tp_accept_off",    32'(tROB_probeSetFinBit_OUT), 32'd0);

        // Round robin with all three continuously valid.
        do_flush();
        set_rob(0, 20, 1'b0);
        set_req(0, 1, 10, 0, 0, 32'h1000);
        set_req(1, 1, 11, 1, 0, 32'h1100);
        set_req(2, 1, 12, 0, 1, 32'h1200);
        strobes.delete();
        for (int c = 0; c < 7; c++) tick();
        cmplValid_IN = '0;
        check("rr_count", 32'(strobes.size()), 32'd6);
        for (int k = 0; k < 6 && k < strobes.size(); k++)
            check($sformatf("rr_order%0d", k), 32'(strobes[k]), 32'(10 + (k % 3)));

        // Wrapped ROB window: 62 and 2 live, 30 stale.
        do_flush();
        for (int c = 0; c < 3; c++) tick();
        set_rob(60, 4, 1'b0);
        set_req(0, 1, 62, 0, 0, 32'h2000);
        set_req(1, 1, 2,  1, 1, 32'h2100);
        set_req(2, 1, 30, 0, 0, 32'h2200);
        strobes.delete();
        tick();
        cmplValid_IN = '0;
        for (int c = 0; c < 4; c++) tick();
        check("wrap_count", 32'(strobes.size()), 32'd2);
        if (strobes.size() == 2) begin
            check("wrap_first",  32'(strobes[0]), 32'd62);
            check("wrap_second", 32'(strobes[1]), 32'd2);
        end
        check("wrap_drop", 32'(dropCount_OUT), 32'd1);
        set_rob(7, 7, 1'b1);
        set_req(0, 1, 0, 0, 0, 32'h2300);
        tick();
        cmplValid_IN = '0;
        tick(); tick();
        check("empty_drop", 32'(dropCount_OUT), 32'd2);

        // Flush with all three held; next grant must go to requester 0.
        set_rob(0, 20, 1'b0);
        set_req(0, 1, 1, 0, 0, 32'h3000);
        set_req(1, 1, 2, 0, 0, 32'h3100);
        set_req(2, 1, 3, 0, 0, 32'h3200);
        tick();
        strobes.delete();
        do_flush();
        check("flush_fin", 32'(tROB_probeSetFinBit_OUT), 32'd0);
        tick();
        check("flush_no_strobe", 32'(strobes.size()), 32'd0);
        set_req(0, 1, 14, 0, 0, 32'h3300);
        set_req(1, 1, 15, 0, 0, 32'h3400);
        set_req(2, 1, 16, 0, 0, 32'h3500);
        tick();
        cmplValid_IN = '0;
        for (int c = 0; c < 4; c++) tick();
        if (strobes.size() > 0) check("flush_first", 32'(strobes[0]), 32'd14);
        else check("flush_first", 32'hFFFF_FFFF, 32'd14);

        // FREEZE preserves held entries and the round-robin pointer.
        set_req(1, 1, 9, 0, 0, 32'h4000);
        tick();
        cmplValid_IN = '0;
        tick();
        set_req(0, 1, 4, 1, 0, 32'h4100);
        set_req(1, 1, 5, 0, 1, 32'h4200);
        set_req(2, 1, 6, 1, 1, 32'h4300);
        tick();
        cmplValid_IN = '0;
        FREEZE = 1'b1;
        strobes.delete();
        for (int c = 0; c < 4; c++) tick();
        check("freeze_no_strobe", 32'(strobes.size()), 32'd0);
        FREEZE = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        check("freeze_count", 32'(strobes.size()), 32'd3);
        if (strobes.size() == 3) begin
            check("freeze_order0", 32'(strobes[0]), 32'd6);
            check("freeze_order1", 32'(strobes[1]), 32'd4);
            check("freeze_order2", 32'(strobes[2]), 32'd5);
        end

        // Counter saturation with a steady stream of stale records.
        set_rob(7, 7, 1'b1);
        for (int c = 0; c < 302; c++) begin
            set_req(0, 1, int'($urandom_range(0, DEPTH - 1)), 0, 0, $urandom);
            tick();
        end
        cmplValid_IN = '0;
        tick(); tick();
        check("sat_drop", 32'(dropCount_OUT), 32'd255);

        // Random traffic.
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < 3; i++)
                set_req(i, bit'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                        bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), $urandom);
            begin
                int h;
                h = int'($urandom_range(0, DEPTH - 1));
                if ($urandom_range(0, 3) == 0) set_rob(h, h, bit'($urandom_range(0, 1)));
                else set_rob(h, int'($urandom_range(0, DEPTH - 1)), 1'b0);
            end
            flush_IN = ($urandom_range(0, 19) == 0);
            FREEZE   = ($urandom_range(0, 9) == 0);
            RESET    = ($urandom_range(0, 99) == 0);
            tick();
        end
        RESET = 1'b0; FREEZE = 1'b0; flush_IN = 1'b0; cmplValid_IN = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
